// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the SoC core for the button conditioner.
// The release and repeat events carry a _pulse suffix because the bare words are SV keywords.
interface button_conditioner_if #(
    parameter int N_BUTTONS = 2
);
    logic [N_BUTTONS-1:0] btn_n;
    logic [N_BUTTONS-1:0] level;
    logic [N_BUTTONS-1:0] press;
    logic [N_BUTTONS-1:0] release_pulse;
    logic [N_BUTTONS-1:0] repeat_pulse;

    modport master (
        output btn_n,
        input  level,
        input  press,
        input  release_pulse,
        input  repeat_pulse
    );

    modport slave (
        input  btn_n,
        output level,
        output press,
        output release_pulse,
        output repeat_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel push-button front end: 2-flop synchroniser with inversion, counter debouncer,
// and registered press/release/auto-repeat pulse generation. Channels share no state.
module button_conditioner #(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int REPEAT_DELAY    = 12000000,
    parameter int REPEAT_PERIOD   = 3000000
) (
    input logic                 clk,
    input logic                 reset,
    button_conditioner_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        logic            s1_r;
        logic            s2_r;
        logic            level_r;
        logic            press_r;
        logic            release_r;
        logic [DB_W-1:0] db_cnt_r;
        logic [DB_W-1:0] db_cnt_s;
        logic            level_s;
        logic            press_s;
        logic            release_s;

        // Debounce next state: any return of s2 to the current level restarts the count.
        always_comb begin
            db_cnt_s  = db_cnt_r;
            level_s   = level_r;
            press_s   = 1'b0;
            release_s = 1'b0;
            if (s2_r == level_r) begin
                db_cnt_s = {DB_W{1'b0}};
            end else if (db_cnt_r == DB_LAST) begin
                db_cnt_s  = {DB_W{1'b0}};
                level_s   = s2_r;
                press_s   = s2_r;
                release_s = ~s2_r;
            end else begin
                db_cnt_s = db_cnt_r + DB_W'(1);
            end
        end

        // Synchroniser, debounce counter and event registers.
        always_ff @(posedge clk) begin
            if (!reset) begin
                s1_r      <= 1'b0;
                s2_r      <= 1'b0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                db_cnt_r  <= {DB_W{1'b0}};
            end else begin
                s1_r      <= ~bus.btn_n[i];
                s2_r      <= s1_r;
                level_r   <= level_s;
                press_r   <= press_s;
                release_r <= release_s;
                db_cnt_r  <= db_cnt_s;
            end
        end

        assign bus.level[i]         = level_r;
        assign bus.press[i]         = press_r;
        assign bus.release_pulse[i] = release_r;

        if (REPEAT_PERIOD != 0) begin : g_rpt
            localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RP_W   = $clog2(RP_MAX + 1);
            localparam logic [RP_W-1:0] RP_DELAY_LOAD  = RP_W'(REPEAT_DELAY - 1);
            localparam logic [RP_W-1:0] RP_PERIOD_LOAD = RP_W'(REPEAT_PERIOD - 1);

            logic [RP_W-1:0] rp_cnt_r;
            logic [RP_W-1:0] rp_cnt_s;
            logic            repeat_r;
            logic            repeat_s;

            // Repeat next state: a falling level in this cycle clears the counter before any pulse.
            always_comb begin
                rp_cnt_s = rp_cnt_r;
                repeat_s = 1'b0;
                if (level_s && !level_r) begin
                    rp_cnt_s = RP_DELAY_LOAD;
                end else if (level_r && level_s) begin
                    if (rp_cnt_r == {RP_W{1'b0}}) begin
                        repeat_s = 1'b1;
                        rp_cnt_s = RP_PERIOD_LOAD;
                    end else begin
                        rp_cnt_s = rp_cnt_r - RP_W'(1);
                    end
                end else begin
                    rp_cnt_s = {RP_W{1'b0}};
                end
            end

            // Repeat counter and pulse register.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    rp_cnt_r <= {RP_W{1'b0}};
                    repeat_r <= 1'b0;
                end else begin
                    rp_cnt_r <= rp_cnt_s;
                    repeat_r <= repeat_s;
                end
            end

            assign bus.repeat_pulse[i] = repeat_r;
        end else begin : g_no_rpt
            assign bus.repeat_pulse[i] = 1'b0;
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_button_conditioner;
    localparam int N = 2;

    typedef struct {
        logic       rst;
        logic [1:0] btn_n;
        logic [1:0] level;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] rpt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    button_conditioner_if #(.N_BUTTONS(N)) bus();

    button_conditioner #(
        .N_BUTTONS(N),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Inputs are set before an edge; outputs are looked at 1 time unit after it.
    task automatic step(input logic r, input logic [1:0] b);
        reset     = r;
        bus.btn_n = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [1:0] el,
                         input logic [1:0] ep, input logic [1:0] er, input logic [1:0] erp);
        n_cmp++;
        if ({bus.level, bus.press, bus.release_pulse, bus.repeat_pulse} !== {el, ep, er, erp}) begin
            n_bad++;
            $display("FAIL %s[%0d]: got level=%b press=%b release=%b repeat=%b, want level=%b press=%b release=%b repeat=%b",
                     name, idx, bus.level, bus.press, bus.release_pulse, bus.repeat_pulse, el, ep, er, erp);
        end
    endtask

    vec_t tbl [23];

    initial begin
        int pulses;

        // Rows 0-2 reset with both pressed; row 3 is the first free edge, so both press at row 8.
        // Both released from row 9 -> release at row 14. Channel 0 alone pressed from row 16 -> row 21.
        for (int j = 0; j < 23; j++) begin
            tbl[j].rst   = (j >= 3) ? 1'b1 : 1'b0;
            tbl[j].btn_n = (j <= 8) ? 2'b00 : ((j <= 15) ? 2'b11 : 2'b10);
            tbl[j].level = 2'b00;
            tbl[j].press = 2'b00;
            tbl[j].rel   = 2'b00;
            tbl[j].rpt   = 2'b00;
        end
        tbl[8].press  = 2'b11;
        for (int j = 8; j <= 13; j++) tbl[j].level = 2'b11;
        tbl[14].rel   = 2'b11;
        tbl[21].level = 2'b01;
        tbl[21].press = 2'b01;
        tbl[22].level = 2'b01;

        for (int j = 0; j < 23; j++) begin
            step(tbl[j].rst, tbl[j].btn_n);
            check("table", j, tbl[j].level, tbl[j].press, tbl[j].rel, tbl[j].rpt);
        end

        // Auto-repeat: press was at c=0 (row 21); repeats at c=10,15,20,...
        pulses = 0;
        for (int c = 2; c <= 40; c++) begin
            step(1'b1, 2'b10);
            if (bus.repeat_pulse[0] === 1'b1) pulses++;
            check("hold", c, 2'b01, 2'b00, 2'b00,
                  ((c >= 10) && ((c - 10) % 5 == 0)) ? 2'b01 : 2'b00);
        end
        n_cmp++;
        if (pulses != 7) begin
            n_bad++;
            $display("FAIL repeat_count: got %0d pulses, want 7", pulses);
        end

        // Release from c=41: level drops at c=46; c=45 still repeats, nothing after.
        for (int c = 41; c <= 55; c++) begin
            step(1'b1, 2'b11);
            check("hold_release", c, (c < 46) ? 2'b01 : 2'b00, 2'b00,
                  (c == 46) ? 2'b01 : 2'b00,
                  ((c < 46) && ((c - 10) % 5 == 0)) ? 2'b01 : 2'b00);
        end

        // Bounce: 2 low / 2 high for 20 cycles, then low from b=20 -> level at b=25.
        for (int b = 0; b < 30; b++) begin
            step(1'b1, {1'b1, (b < 20) ? (((b / 2) % 2) == 1) : 1'b0});
            check("bounce", b, (b >= 25) ? 2'b01 : 2'b00, (b == 25) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'b11);
            check("bounce_release", i, (i < 5) ? 2'b01 : 2'b00, 2'b00,
                  (i == 5) ? 2'b01 : 2'b00, 2'b00);
        end

        // Short hold: press at h=5, level falls at h=15 (press+10) -> no repeat in release cycle.
        for (int h = 0; h <= 20; h++) begin
            step(1'b1, (h < 10) ? 2'b10 : 2'b11);
            check("short", h, ((h >= 5) && (h <= 14)) ? 2'b01 : 2'b00,
                  (h == 5) ? 2'b01 : 2'b00, (h == 15) ? 2'b01 : 2'b00, 2'b00);
        end

        // Mid-operation reset on channel 1 at m=13; still held -> fresh press at m=19.
        for (int m = 0; m <= 26; m++) begin
            step((m == 13) ? 1'b0 : 1'b1, 2'b01);
            check("midreset", m,
                  (((m >= 5) && (m <= 12)) || (m >= 19)) ? 2'b10 : 2'b00,
                  ((m == 5) || (m == 19)) ? 2'b10 : 2'b00, 2'b00, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
